// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte producers. A requester is
// picked by round-robin, its byte is latched onto tx_data and a one-cycle
// tx_start pulse is issued. The arbiter then keeps ownership until the
// transmitter has raised and dropped tx_busy for that frame. If tx_busy never
// rises within BUSY_TIMEOUT cycles the transfer is abandoned with a one-cycle
// err_timeout pulse.
//
// Optional feature (compile-time macro): UART_ARB_LOCK_EN
//   When defined, a requester that holds req_lock and req high when its frame
//   completes is granted again ahead of the rotation (multi-byte frames stay
//   contiguous). When undefined, req_lock is ignored.
//
// Parameters:
//   NUM_REQ       number of requesters (2..8)
//   BUSY_TIMEOUT  cycles to wait for tx_busy to rise after tx_start
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   req          per-requester byte valid (level)
//   req_data     requester i byte in [8i+7:8i]
//   req_lock     per-requester frame hold (lock build only)
//   gnt          one-hot, one-cycle: granted requester's byte was consumed
//   tx_data      byte to the transmitter, stable from grant until idle
//   tx_start     one-cycle start pulse to the transmitter
//   tx_busy      transmitter frame-in-progress flag
//   owner        index of current or last grantee
//   active       high whenever the arbiter is not idle
//   err_timeout  one-cycle pulse when tx_busy failed to rise in time
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       active,
    output logic                       err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]         state_q,    state_d;
    logic [NUM_REQ-1:0] gnt_q,      gnt_d;
    logic [7:0]         tx_data_q,  tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [IDX_W-1:0]   owner_q,    owner_d;
    logic               active_q,   active_d;
    logic               err_q,      err_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [IDX_W-1:0]   ptr_q,      ptr_d;

    // -------------------------------------------------------------------------
    // Per-requester byte view
    // -------------------------------------------------------------------------
    logic [7:0] req_byte [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
        assign req_byte[gi] = req_data[8*gi +: 8];
    end

    // -------------------------------------------------------------------------
    // Round-robin search. Slot gi of the rotated view holds requester
    // (ptr+1+gi) mod NUM_REQ, so slot 0 is the highest priority. The sum is one
    // bit wider than an index, which is enough for ptr+NUM_REQ.
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]   rot_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_req;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [IDX_W:0] sum;
        assign sum = {1'b0, ptr_q} + (IDX_W+1)'(gi + 1);
        assign rot_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                           ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                           : IDX_W'(sum);
        assign rot_req[gi] = req[rot_idx[gi]];
    end

    logic [IDX_W-1:0] rr_idx;

    // Scan from lowest priority upward so the highest-priority hit wins.
    always_comb begin
        rr_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                rr_idx = rot_idx[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame lock
    // -------------------------------------------------------------------------
    logic lock_hit;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;

    // Lock only steers the grant if the owner still has a byte ready;
    // otherwise the normal rotation applies.
    assign lock_hit = lock_q & req[owner_q];

    always_comb begin
        lock_d = lock_q;
        case (state_q)
            S_IDLE: begin
                if (!tx_busy && (|req)) begin
                    lock_d = 1'b0;
                end
            end
            S_WAIT_BUSY: begin
                // A timeout abandons the frame, so the hold is released.
                if (!tx_busy && (cnt_q == CNT_W'(BUSY_TIMEOUT - 1))) begin
                    lock_d = 1'b0;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    lock_d = req_lock[owner_q] & req[owner_q];
                end
            end
            default: lock_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_req_lock;

    assign lock_hit        = 1'b0;
    assign unused_req_lock = ^req_lock;
`endif

    logic [IDX_W-1:0] win_idx;
    logic             launch;

    assign win_idx = lock_hit ? owner_q : rr_idx;
    assign launch  = (state_q == S_IDLE) && !tx_busy && (|req);

    // -------------------------------------------------------------------------
    // Next-state logic. gnt, tx_start and err_timeout default low so each is
    // a single-cycle pulse.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        tx_start_d = 1'b0;
        err_d      = 1'b0;
        tx_data_d  = tx_data_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d          = S_WAIT_BUSY;
                    gnt_d[win_idx]   = 1'b1;
                    tx_start_d       = 1'b1;
                    tx_data_d        = req_byte[win_idx];
                    owner_d          = win_idx;
                    ptr_d            = win_idx;
                    cnt_d            = '0;
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // ptr keeps the failed grantee so others go first next.
                    if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        active_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            owner_q    <= '0;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            // Last grantee = NUM_REQ-1 so requester 0 is searched first.
            ptr_q      <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            owner_q    <= owner_d;
            active_q   <= active_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign gnt         = gnt_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign owner       = owner_q;
    assign active      = active_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Scenario tasks drive the arbiter with 4 requesters (bytes 0x41..0x44) and a
// hand-driven tx_busy. Expected grants are queued when requests are raised and
// popped when tx_start is seen.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  owner;
    logic        active;
    logic        err_timeout;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .BUSY_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .req_lock    (req_lock),
        .gnt         (gnt),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .owner       (owner),
        .active      (active),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_lock = 4'b0000;
        tx_busy  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits (bounded) until tx_start is observed; cycles = ticks taken.
    task automatic wait_start(output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int c = 0; c < 40; c++) begin
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    task automatic finish_xfer();
        tx_busy = 1'b1;
        tick();
        tick();
        tx_busy = 1'b0;
        tick();
        tick();
    endtask

    function automatic exp_t mk(input int idx);
        exp_t e;
        e.idx  = 2'(idx);
        e.data = 8'h41 + 8'(idx);
        return e;
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        exp_t e;
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_lock = 4'b0000;
        tx_busy  = 1'b0;
        tick();
        tick();
        total++;
        if ({gnt, tx_start, tx_data, owner, active, err_timeout} !== 17'h0) begin
            bad++;
            $display("FAIL reset_outputs: got gnt=%b start=%b data=%h owner=%0d active=%b err=%b, want all zero",
                     gnt, tx_start, tx_data, owner, active, err_timeout);
        end
        rst_n = 1'b1;
        tick();
        req = 4'b1111;
        sb.push_back(mk(0));
        tick();
        e = sb.pop_front();
        $display("txn reset_first: gnt=%b owner=%0d data=%h", gnt, owner, tx_data);
        total++;
        if (tx_start !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_start: got %b want 1", tx_start);
        end
        total++;
        if (gnt !== (4'b0001 << e.idx)) begin
            bad++;
            $display("FAIL reset_first_gnt: got %b want %b", gnt, 4'b0001 << e.idx);
        end
        total++;
        if (owner !== e.idx || tx_data !== e.data) begin
            bad++;
            $display("FAIL reset_first_owner_data: got %0d/%h want %0d/%h", owner, tx_data, e.idx, e.data);
        end
        total++;
        if (active !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_active: got %b want 1", active);
        end
        req = 4'b0000;
        tick();
        total++;
        if (gnt !== 4'b0000 || tx_start !== 1'b0) begin
            bad++;
            $display("FAIL pulse_width: got gnt=%b start=%b want 0000/0", gnt, tx_start);
        end
        finish_xfer();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_fairness();
        exp_t e;
        bit   ok;
        int   cyc;
        reset_dut();
        for (int n = 0; n < 5; n++) sb.push_back(mk(n % 4));
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_start(ok, cyc);
            e = sb.pop_front();
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL fair_timeout_%0d: got no tx_start want start", n);
            end
            $display("txn fair_%0d: gnt=%b owner=%0d data=%h", n, gnt, owner, tx_data);
            total++;
            if (gnt !== (4'b0001 << e.idx) || owner !== e.idx || tx_data !== e.data) begin
                bad++;
                $display("FAIL fair_grant_%0d: got gnt=%b owner=%0d data=%h want gnt=%b owner=%0d data=%h",
                         n, gnt, owner, tx_data, 4'b0001 << e.idx, e.idx, e.data);
            end
            if (n > 0) begin
                total++;
                if (cyc !== 2) begin
                    bad++;
                    $display("FAIL fair_turnaround_%0d: got %0d cycles want 2", n, cyc);
                end
            end
            tx_busy = 1'b1;
            repeat (10) tick();
            tx_busy = 1'b0;
            if (n == 4) req = 4'b0000;
        end
        tick();
        tick();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_blocked();
        exp_t e;
        int   early;
        reset_dut();
        tx_busy = 1'b1;
        req     = 4'b0100;
        early   = 0;
        repeat (5) begin
            tick();
            if (gnt !== 4'b0000 || tx_start !== 1'b0) early++;
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL blocked_no_grant: got %0d grant cycles want 0", early);
        end
        tx_busy = 1'b0;
        sb.push_back(mk(2));
        tick();
        e = sb.pop_front();
        $display("txn blocked: gnt=%b owner=%0d data=%h", gnt, owner, tx_data);
        total++;
        if (tx_start !== 1'b1 || gnt !== (4'b0001 << e.idx) || owner !== e.idx || tx_data !== e.data) begin
            bad++;
            $display("FAIL blocked_release: got start=%b gnt=%b owner=%0d data=%h want 1/%b/%0d/%h",
                     tx_start, gnt, owner, tx_data, 4'b0001 << e.idx, e.idx, e.data);
        end
        req = 4'b0000;
        finish_xfer();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_timeout();
        exp_t e;
        int   early;
        reset_dut();
        req = 4'b0100;
        sb.push_back(mk(2));
        tick();
        e = sb.pop_front();
        $display("txn timeout_launch: gnt=%b owner=%0d data=%h", gnt, owner, tx_data);
        total++;
        if (tx_start !== 1'b1 || owner !== e.idx) begin
            bad++;
            $display("FAIL timeout_launch: got start=%b owner=%0d want 1/%0d", tx_start, owner, e.idx);
        end
        req   = 4'b0000;
        early = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c < 15 && err_timeout !== 1'b0) early++;
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL timeout_early: got %0d early pulses want 0", early);
        end
        total++;
        if (err_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_pulse: got %b want 1 at cycle 15", err_timeout);
        end
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: got active=%b want 0", active);
        end
        req = 4'b0101;
        sb.push_back(mk(0));
        tick();
        e = sb.pop_front();
        $display("txn timeout_next: gnt=%b owner=%0d data=%h", gnt, owner, tx_data);
        total++;
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_one_cycle: got %b want 0", err_timeout);
        end
        total++;
        if (gnt !== (4'b0001 << e.idx) || owner !== e.idx || tx_data !== e.data) begin
            bad++;
            $display("FAIL timeout_next_grant: got gnt=%b owner=%0d data=%h want %b/%0d/%h",
                     gnt, owner, tx_data, 4'b0001 << e.idx, e.idx, e.data);
        end
        req = 4'b0000;
        finish_xfer();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid();
        exp_t e;
        int   spurious;
        reset_dut();
        req = 4'b1000;
        sb.push_back(mk(3));
        tick();
        e = sb.pop_front();
        $display("txn mid_launch: gnt=%b owner=%0d data=%h", gnt, owner, tx_data);
        total++;
        if (owner !== e.idx || tx_data !== e.data) begin
            bad++;
            $display("FAIL mid_launch: got %0d/%h want %0d/%h", owner, tx_data, e.idx, e.data);
        end
        req     = 4'b0000;
        tx_busy = 1'b1;
        tick();
        tick();
        total++;
        if (active !== 1'b1) begin
            bad++;
            $display("FAIL mid_active: got %b want 1", active);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (active !== 1'b0 || tx_start !== 1'b0 || owner !== 2'd0 || tx_data !== 8'h00) begin
            bad++;
            $display("FAIL mid_async_reset: got active=%b start=%b owner=%0d data=%h want 0/0/0/00",
                     active, tx_start, owner, tx_data);
        end
        tick();
        rst_n   = 1'b1;
        tx_busy = 1'b0;
        spurious = 0;
        repeat (3) begin
            tick();
            if (tx_start !== 1'b0 || gnt !== 4'b0000) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++;
            $display("FAIL mid_no_grant: got %0d grant cycles want 0", spurious);
        end
        req = 4'b0010;
        sb.push_back(mk(1));
        tick();
        e = sb.pop_front();
        $display("txn mid_after: gnt=%b owner=%0d data=%h", gnt, owner, tx_data);
        total++;
        if (tx_start !== 1'b1 || gnt !== (4'b0001 << e.idx) || tx_data !== e.data) begin
            bad++;
            $display("FAIL mid_after_grant: got start=%b gnt=%b data=%h want 1/%b/%h",
                     tx_start, gnt, tx_data, 4'b0001 << e.idx, e.data);
        end
        req = 4'b0000;
        finish_xfer();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_lock();
        exp_t e;
        bit   ok;
        int   cyc;
`ifdef UART_ARB_LOCK_EN
        int   seq[4] = '{1, 1, 1, 0};
`else
        int   seq[4] = '{1, 0, 1, 0};
`endif
        reset_dut();
        for (int n = 0; n < 4; n++) sb.push_back(mk(seq[n]));
        req      = 4'b0010;
        req_lock = 4'b0010;
        for (int n = 0; n < 4; n++) begin
            wait_start(ok, cyc);
            e = sb.pop_front();
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL lock_timeout_%0d: got no tx_start want start", n);
            end
            $display("txn lock_%0d: gnt=%b owner=%0d data=%h", n, gnt, owner, tx_data);
            total++;
            if (gnt !== (4'b0001 << e.idx) || owner !== e.idx || tx_data !== e.data) begin
                bad++;
                $display("FAIL lock_grant_%0d: got gnt=%b owner=%0d data=%h want %b/%0d/%h",
                         n, gnt, owner, tx_data, 4'b0001 << e.idx, e.idx, e.data);
            end
            if (n == 0) req = 4'b0011;
            tx_busy = 1'b1;
            repeat (4) tick();
            if (n == 2) req_lock = 4'b0000;
            if (n == 3) req = 4'b0000;
            tx_busy = 1'b0;
        end
        tick();
        tick();
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_lock = 4'b0000;
        tx_busy  = 1'b0;
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'h41 + 8'(i);
        test_reset();
        test_fairness();
        test_blocked();
        test_timeout();
        test_reset_mid();
        test_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART `Transmitter` between several byte-producing requesters. It owns the transmitter's start/data handshake: it picks one requester, latches its byte onto the transmitter data bus, and issues a one-cycle start pulse. It then holds ownership until the transmitter reports the frame complete. It sits between the user-logic sources and the `Transmitter` instance inside the top-level UART wrapper.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `BUSY_TIMEOUT`, default 15: cycles to wait for `tx_busy` to rise after `tx_start` before aborting.

Ports:
- `clk`: input, 1 bit. Single clock.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `req`: input, `NUM_REQ` bits. Per-requester byte-valid, level.
- `req_data`: input, `NUM_REQ*8` bits. Requester i's byte is in slice [8i+7:8i].
- `req_lock`: input, `NUM_REQ` bits. Multi-byte frame hold; only honoured when `UART_ARB_LOCK_EN` is defined.
- `gnt`: output, `NUM_REQ` bits. One-hot, one-cycle pulse; the byte from the granted requester has been consumed.
- `tx_data`: output, 8 bits. Byte to the transmitter. Held stable from grant until return to IDLE.
- `tx_start`: output, 1 bit. One-cycle start pulse to the transmitter.
- `tx_busy`: input, 1 bit. Transmitter frame-in-progress flag.
- `owner`: output, `$clog2(NUM_REQ)` bits. Index of the current or last grantee.
- `active`: output, 1 bit. High in any state other than IDLE.
- `err_timeout`: output, 1 bit. One-cycle pulse when the `tx_busy` handshake times out.

## Operation
- FSM has three states: IDLE, WAIT_BUSY, WAIT_DONE. All outputs are registered.
- IDLE: if `tx_busy`=0 and any `req` bit is set, select a winner by round-robin and transition to WAIT_BUSY. On that same edge:
  - `gnt[winner]` is set.
  - `tx_start` is set.
  - `tx_data` is loaded with `req_data[winner]`.
  - `owner` is loaded with the winner index.
  - The timeout counter is cleared.
- If `tx_busy`=1 in IDLE, no grant is issued; the arbiter waits.
- Round-robin: search begins at `ptr+1` modulo `NUM_REQ`, where `ptr` is the last grantee. `ptr` is updated at the grant edge.
- WAIT_BUSY: `gnt` and `tx_start` are already deasserted (pulses last one cycle).
  - `tx_busy`=1 → WAIT_DONE.
  - Otherwise the counter increments. On reaching `BUSY_TIMEOUT` → IDLE with `err_timeout` pulsed for one cycle. `ptr` keeps the grantee, so the failed requester does not immediately retry ahead of others.
- WAIT_DONE: `tx_busy`=0 → IDLE.
- Requester contract: drop `req` or present the next byte in the cycle after seeing `gnt`. A `req` deassertion after the grant has no effect on the transfer in flight.
- The grant edge registers `gnt`, so the arbiter has already left IDLE when the requester sees it. No double grant is possible.
- Reset (asynchronous, any state): state=IDLE; `gnt`=0; `tx_start`=0; `tx_data`=0x00; `owner`=0; `active`=0; `err_timeout`=0; counter=0; `ptr`=`NUM_REQ`-1, so requester 0 has first priority.

## Timing
- Request latency: `req` sampled high at edge k (idle, `tx_busy` low) → `gnt`, `tx_start` and `tx_data` are valid in cycle k+1, for one cycle.
- Turn-around: `tx_busy` falls and is sampled at edge m → IDLE at m. The earliest next `tx_start` is registered at edge m+1.
- Simultaneous requests: exactly one grant per transfer, by rotation. No requester waits more than `NUM_REQ`-1 transfers.
- Timeout: `err_timeout` pulses exactly `BUSY_TIMEOUT` cycles after the `tx_start` cycle when `tx_busy` never rises.

## Configuration
- `UART_ARB_LOCK_EN` defined: at the WAIT_DONE→IDLE exit, if `req_lock[owner]` and `req[owner]` are both high, the next grant goes to `owner` regardless of rotation. This keeps multi-byte frames contiguous. A timeout releases the lock.
- `UART_ARB_LOCK_EN` undefined: `req_lock` is ignored and pure round-robin applies.

## Test plan
- **Reset:** after reset, all outputs are zero. `req`=4'b1111 → first grant is `gnt`=4'b0001, `owner`=0, with `tx_data` equal to requester 0's byte, e.g. 0x41.
- **Fairness:** hold `req`=4'b1111 and model `tx_busy` high for 10 cycles per byte → grant order is 0,1,2,3,0, each with the matching byte on `tx_data`.
- **Blocked launch:** `tx_busy`=1 while idle with `req`=4'b0100 → no grant. Release `tx_busy` → grant issued the following cycle with `owner`=2.
- **Timeout:** `tx_busy` stuck at 0 after `tx_start` → `err_timeout` pulses exactly 15 cycles later. Next `req`=4'b0101 → requester 0 is granted.
- **Reset mid-transfer:** assert `rst_n`=0 in WAIT_DONE → `active`=0 and `tx_start`=0 immediately. After release, no grant is issued until `req` is sampled.
- **Lock (macro defined):** `req`=4'b0011 with `req_lock`=4'b0010 after a grant to requester 1 → three consecutive grants to 1. Drop the lock → the next grant goes to 0.
